axi_addr_fifo_mc: RTL and testbench



---
 rtl/axi_addr_fifo_pkg.sv | 22 ++
 rtl/axi_addr_fifo_ch_ctl.sv | 76 +++++++
 rtl/axi_addr_fifo_mc.sv | 114 +++++++++++
 tb/tb_axi_addr_fifo_mc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_addr_fifo_pkg.sv
// Shared constants and width/slice helpers for the multi-channel address FIFO.
package axi_addr_fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 64;
    localparam int DEF_FIFO_DEPTH = 32;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_AF_LEVEL   = 3;

    // One extra bit over the address width acts as the wrap bit.
    function automatic int calc_cnt_wid(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int calc_ch_wid(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int cnt_lsb(input int ch, input int cnt_wid);
        return ch * cnt_wid;
    endfunction

endpackage

// File: rtl/axi_addr_fifo_ch_ctl.sv
// Per-channel pointer pair, status flags and occupancy for axi_addr_fifo_mc.
// Optional sticky ovf/udf flags are built when AXI_ADDR_FIFO_MC_ERR_EN is defined.
module axi_addr_fifo_ch_ctl
    import axi_addr_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int AF_LEVEL     = DEF_AF_LEVEL,
    parameter int FIFO_CNT_WID = calc_cnt_wid(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic                    push_sel,
    input  logic                    pop_sel,
    output logic                    push_ack,
    output logic                    pop_ack,
    output logic                    empty,
    output logic                    full,
    output logic                    afull,
    output logic [FIFO_CNT_WID-1:0] word_cnt,
    output logic [FIFO_CNT_WID-2:0] wr_addr,
    output logic [FIFO_CNT_WID-2:0] rd_addr
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
    ,
    output logic                    ovf,
    output logic                    udf
`endif
);

    localparam logic [FIFO_CNT_WID-1:0] AF_THR = FIFO_CNT_WID'(FIFO_DEPTH - AF_LEVEL);
    localparam int MSB = FIFO_CNT_WID - 1;

    logic [FIFO_CNT_WID-1:0] wr_ptr_reg;
    logic [FIFO_CNT_WID-1:0] rd_ptr_reg;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[MSB] != rd_ptr_reg[MSB]) &&
                      (wr_ptr_reg[MSB-1:0] == rd_ptr_reg[MSB-1:0]);
    assign word_cnt = wr_ptr_reg - rd_ptr_reg;
    assign afull    = (word_cnt >= AF_THR);
    assign wr_addr  = wr_ptr_reg[MSB-1:0];
    assign rd_addr  = rd_ptr_reg[MSB-1:0];

    // Flags are pre-cycle, so a full channel takes a pop but not a push.
    assign push_ack = push_sel && !full && !init;
    assign pop_ack  = pop_sel && !empty && !init;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ack) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ack)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

`ifdef AXI_ADDR_FIFO_MC_ERR_EN
    logic ovf_reg;
    logic udf_reg;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            if (push_sel && full) ovf_reg <= 1'b1;
            if (pop_sel && empty) udf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
    assign udf = udf_reg;
`endif

endmodule

// File: rtl/axi_addr_fifo_mc.sv
// Multi-channel address/command FIFO: NUM_CH queues in one shared array, registered read port.
// Define AXI_ADDR_FIFO_MC_ERR_EN to add sticky per-channel ovf/udf outputs.
module axi_addr_fifo_mc
    import axi_addr_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH   = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int AF_LEVEL     = DEF_AF_LEVEL,
    parameter int FIFO_CNT_WID = calc_cnt_wid(FIFO_DEPTH),
    parameter int CH_WID       = calc_ch_wid(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [CH_WID-1:0]              push_ch,
    input  logic [FIFO_WIDTH-1:0]          push_data,
    output logic                           push_ack,
    input  logic                           pop,
    input  logic [CH_WID-1:0]              pop_ch,
    output logic                           pop_ack,
    output logic [FIFO_WIDTH-1:0]          pop_data,
    output logic                           pop_vld,
    input  logic [NUM_CH-1:0]              init,
    output logic [NUM_CH-1:0]              empty,
    output logic [NUM_CH-1:0]              full,
    output logic [NUM_CH-1:0]              afull,
    output logic [NUM_CH*FIFO_CNT_WID-1:0] word_cnt
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
    ,
    output logic [NUM_CH-1:0]              ovf,
    output logic [NUM_CH-1:0]              udf
`endif
);

    localparam int AW = FIFO_CNT_WID - 1;

    logic [FIFO_WIDTH-1:0] mem [NUM_CH*FIFO_DEPTH];

    logic [NUM_CH-1:0] push_sel;
    logic [NUM_CH-1:0] pop_sel;
    logic [NUM_CH-1:0] push_ack_ch;
    logic [NUM_CH-1:0] pop_ack_ch;
    logic [AW-1:0]     wr_addr [NUM_CH];
    logic [AW-1:0]     rd_addr [NUM_CH];
    logic [AW-1:0]     wr_addr_sel;
    logic [AW-1:0]     rd_addr_sel;
    logic [FIFO_WIDTH-1:0] pop_data_reg;
    logic                  pop_vld_reg;

    // Equality decode means an out-of-range select matches no channel.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign push_sel[gi] = push && (push_ch == CH_WID'(gi));
            assign pop_sel[gi]  = pop  && (pop_ch  == CH_WID'(gi));

            axi_addr_fifo_ch_ctl #(
                .FIFO_DEPTH   (FIFO_DEPTH),
                .AF_LEVEL     (AF_LEVEL),
                .FIFO_CNT_WID (FIFO_CNT_WID)
            ) u_ch_ctl (
                .clk      (clk),
                .rst      (rst),
                .init     (init[gi]),
                .push_sel (push_sel[gi]),
                .pop_sel  (pop_sel[gi]),
                .push_ack (push_ack_ch[gi]),
                .pop_ack  (pop_ack_ch[gi]),
                .empty    (empty[gi]),
                .full     (full[gi]),
                .afull    (afull[gi]),
                .word_cnt (word_cnt[cnt_lsb(gi, FIFO_CNT_WID) +: FIFO_CNT_WID]),
                .wr_addr  (wr_addr[gi]),
                .rd_addr  (rd_addr[gi])
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
                ,
                .ovf      (ovf[gi]),
                .udf      (udf[gi])
`endif
            );
        end
    endgenerate

    assign push_ack = |push_ack_ch;
    assign pop_ack  = |pop_ack_ch;

    always_comb begin
        wr_addr_sel = '0;
        rd_addr_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_sel[c]) wr_addr_sel = wr_addr[c];
            if (pop_sel[c])  rd_addr_sel = rd_addr[c];
        end
    end

    // Storage is never reset; a flushed channel simply re-uses stale entries.
    always_ff @(posedge clk) begin
        if (push_ack) mem[{push_ch, wr_addr_sel}] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data_reg <= '0;
            pop_vld_reg  <= 1'b0;
        end else begin
            pop_vld_reg <= pop_ack;
            if (pop_ack) pop_data_reg <= mem[{pop_ch, rd_addr_sel}];
        end
    end

    assign pop_data = pop_data_reg;
    assign pop_vld  = pop_vld_reg;

endmodule

// File: tb/tb_axi_addr_fifo_mc.sv
// Directed scoreboard bench for axi_addr_fifo_mc (default parameters, 4 channels x 32 entries).
module tb_axi_addr_fifo_mc;

    localparam int W = 64;
    localparam int D = 32;
    localparam int N = 4;
    localparam int CW = 6;
    localparam int AF_THR = D - 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [1:0]    push_ch = '0;
    logic [W-1:0]  push_data = '0;
    logic          push_ack;
    logic          pop = 1'b0;
    logic [1:0]    pop_ch = '0;
    logic          pop_ack;
    logic [W-1:0]  pop_data;
    logic          pop_vld;
    logic [N-1:0]  init = '0;
    logic [N-1:0]  empty;
    logic [N-1:0]  full;
    logic [N-1:0]  afull;
    logic [N*CW-1:0] word_cnt;
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
    logic [N-1:0]  ovf;
    logic [N-1:0]  udf;
    logic [N-1:0]  ovf_m = '0;
    logic [N-1:0]  udf_m = '0;
`endif

    axi_addr_fifo_mc dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_ch   (push_ch),
        .push_data (push_data),
        .push_ack  (push_ack),
        .pop       (pop),
        .pop_ch    (pop_ch),
        .pop_ack   (pop_ack),
        .pop_data  (pop_data),
        .pop_vld   (pop_vld),
        .init      (init),
        .empty     (empty),
        .full      (full),
        .afull     (afull),
        .word_cnt  (word_cnt)
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
        ,
        .ovf       (ovf),
        .udf       (udf)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] mq [N][$];
    logic [W-1:0] exp_q [$];
    logic         exp_vld = 1'b0;
    logic [W-1:0] last_data = '0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] e;
        chk("pop_vld", W'(pop_vld), W'(exp_vld));
        if (exp_vld) begin
            e = exp_q.pop_front();
            chk("pop_data", pop_data, e);
            last_data = e;
            $display("pop   data=%0h", pop_data);
        end else begin
            chk("pop_data_hold", pop_data, last_data);
        end
        for (int c = 0; c < N; c++) begin
            chk($sformatf("word_cnt%0d", c), W'(word_cnt[c*CW +: CW]), W'(mq[c].size()));
            chk($sformatf("empty%0d", c), W'(empty[c]), W'(mq[c].size() == 0));
            chk($sformatf("full%0d", c), W'(full[c]), W'(mq[c].size() == D));
            chk($sformatf("afull%0d", c), W'(afull[c]), W'(mq[c].size() >= AF_THR));
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
            chk($sformatf("ovf%0d", c), W'(ovf[c]), W'(ovf_m[c]));
            chk($sformatf("udf%0d", c), W'(udf[c]), W'(udf_m[c]));
`endif
        end
    endtask

    task automatic step(input logic ps, input int pch, input logic [W-1:0] pd,
                        input logic pp, input int pc, input logic [N-1:0] in);
        logic eps;
        logic epp;
        @(negedge clk);
        push = ps; push_ch = pch[1:0]; push_data = pd;
        pop = pp; pop_ch = pc[1:0]; init = in;
        eps = ps && (mq[pch].size() < D) && !in[pch];
        epp = pp && (mq[pc].size() > 0) && !in[pc];
        #1;
        chk("push_ack", W'(push_ack), W'(eps));
        chk("pop_ack", W'(pop_ack), W'(epp));
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
        for (int c = 0; c < N; c++) begin
            if (in[c]) begin
                ovf_m[c] = 1'b0;
                udf_m[c] = 1'b0;
            end else begin
                if (ps && pch == c && mq[c].size() == D) ovf_m[c] = 1'b1;
                if (pp && pc == c && mq[c].size() == 0) udf_m[c] = 1'b1;
            end
        end
`endif
        @(posedge clk);
        exp_vld = epp;
        if (epp) exp_q.push_back(mq[pc].pop_front());
        for (int c = 0; c < N; c++) if (in[c]) mq[c].delete();
        if (eps) mq[pch].push_back(pd);
        #1;
        $display("step  push=%0b ch%0d d=%0h ack=%0b | pop=%0b ch%0d ack=%0b | init=%b",
                 ps, pch, pd, eps, pp, pc, epp, in);
        check_outputs();
    endtask

    task automatic do_reset(input logic pp, input int pc);
        @(negedge clk);
        rst = 1'b1; push = 1'b0; pop = pp; pop_ch = pc[1:0]; init = '0;
        @(posedge clk);
        for (int c = 0; c < N; c++) mq[c].delete();
        exp_q.delete();
        exp_vld = 1'b0;
        last_data = '0;
`ifdef AXI_ADDR_FIFO_MC_ERR_EN
        ovf_m = '0;
        udf_m = '0;
`endif
        #1;
        $display("reset pop=%0b ch%0d", pp, pc);
        check_outputs();
        @(negedge clk);
        rst = 1'b0; pop = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    initial begin
        do_reset(1'b0, 0);

        // Fill channel 1, overflow attempt, then drain in order.
        for (int i = 0; i < D; i++) step(1'b1, 1, W'(32'h1000 + i), 1'b0, 0, '0);
        step(1'b1, 1, W'(64'hDEAD), 1'b0, 0, '0);
        for (int i = 0; i < D; i++) step(1'b0, 0, '0, 1'b1, 1, '0);
        idle();
        step(1'b0, 0, '0, 1'b1, 1, '0);   // pop from empty channel
        step(1'b1, 1, W'(64'h77), 1'b0, 0, '0);

        // Interleaved traffic on ch0/ch3 long enough to wrap ch3 pointers several times.
        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 0) step(1'b1, 0, W'((0 << 16) | i), 1'b1, 3, '0);
            else            step(1'b1, 3, W'((3 << 16) | i), (i % 8 != 1), (i % 8 == 5) ? 0 : 3, '0);
        end
        idle();

        // ch2: simultaneous push/pop when empty, then when full.
        step(1'b1, 2, W'(64'h2000), 1'b1, 2, '0);
        for (int i = 1; i < D; i++) step(1'b1, 2, W'(64'h2000 + i), 1'b0, 0, '0);
        step(1'b1, 2, W'(64'h2FFF), 1'b1, 2, '0);
        step(1'b1, 2, W'(64'h2ABC), 1'b1, 2, '0);
        step(1'b1, 2, W'(64'h2ABD), 1'b0, 0, '0);   // fill again
        step(1'b1, 2, W'(64'h2ABE), 1'b0, 0, '0);   // overflow attempt

        // ch0: flush with a coincident push, then pop from the flushed channel.
        step(1'b0, 0, '0, 1'b0, 0, 4'b0001);
        for (int i = 0; i < 5; i++) step(1'b1, 0, W'(64'h500 + i), 1'b0, 0, '0);
        step(1'b1, 0, W'(64'h5FF), 1'b0, 0, 4'b0001);
        step(1'b0, 0, '0, 1'b1, 0, '0);
        step(1'b1, 0, W'(64'h600), 1'b0, 0, '0);
        step(1'b0, 0, '0, 1'b1, 0, '0);

        // In-flight pop from ch2 completes across a flush of ch2.
        step(1'b0, 0, '0, 1'b1, 2, '0);
        step(1'b0, 0, '0, 1'b1, 2, 4'b0100);
        idle();

        // Reset mid-operation drops the in-flight pop and all contents.
        step(1'b1, 3, W'(64'h3A), 1'b0, 0, '0);
        step(1'b1, 3, W'(64'h3B), 1'b0, 0, '0);
        do_reset(1'b1, 3);
        idle();
        step(1'b1, 3, W'(64'h3C), 1'b0, 0, '0);
        step(1'b0, 0, '0, 1'b1, 3, '0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
